key_event_multi: RTL and testbench



---
 rtl/key_event_pkg.sv | 35 +++
 rtl/key_event_chan.sv | 177 +++++++++++++++++
 rtl/key_event_multi.sv | 51 +++++
 tb/tb_key_event_multi.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
`default_nettype none
// ============================================================================
// Module      : key_event_pkg
// Description : Shared definitions for the multi-channel key event front end.
//               Classifier state encoding, default timing constants (50 MHz)
//               and counter width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package key_event_pkg;

  // Classifier state encoding (3 bits)
  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_press1 = 3'd1;
  localparam logic [2:0] c_st_lhold  = 3'd2;
  localparam logic [2:0] c_st_gap    = 3'd3;
  localparam logic [2:0] c_st_press2 = 3'd4;

  // Default timing at 50 MHz
  localparam int unsigned c_cnt_max    = 999_999;     // 20 ms debounce window
  localparam int unsigned c_double_gap = 14_999_999;  // 300 ms release-to-press gap
  localparam int unsigned c_long_press = 49_999_999;  // 1 s long-press hold

  // Bits needed to hold the values 0..value (never less than one bit)
  function automatic int unsigned cnt_width(input int unsigned value);
    int unsigned w;
    w = $clog2(value + 1);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_chan.sv
`default_nettype none
// ============================================================================
// Module      : key_event_chan
// Description : One key channel: 2-flop synchroniser, debouncer and click
//               classifier (single / double / long press).
// Ports       : clk         - system clock
//               rst         - asynchronous active-high reset
//               key_in      - raw key pin, 0 = pressed
//               key_stable  - debounced level, 0 = pressed
//               single_flag - one-cycle pulse, single click classified
//               double_flag - one-cycle pulse, double click classified
//               long_flag   - one-cycle pulse, long press reached
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_chan
  import key_event_pkg::*;
#(
  parameter int unsigned CNT_MAX    = c_cnt_max,
  parameter int unsigned DOUBLE_GAP = c_double_gap,
  parameter int unsigned LONG_PRESS = c_long_press
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_stable,
  output logic single_flag,
  output logic double_flag,
  output logic long_flag
);

  localparam int unsigned c_deb_w = cnt_width(CNT_MAX);
  // One timer serves both the long-press hold and the double-click gap
  localparam int unsigned c_tm_w  = max_u(cnt_width(DOUBLE_GAP), cnt_width(LONG_PRESS));

  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(CNT_MAX - 1);
  localparam logic [c_deb_w-1:0] c_deb_zero = '0;
  localparam logic [c_deb_w-1:0] c_deb_one  = c_deb_w'(1);
  localparam logic [c_tm_w-1:0]  c_gap_last  = c_tm_w'(DOUBLE_GAP - 1);
  localparam logic [c_tm_w-1:0]  c_long_last = c_tm_w'(LONG_PRESS - 1);
  localparam logic [c_tm_w-1:0]  c_tm_zero   = '0;
  localparam logic [c_tm_w-1:0]  c_tm_one    = c_tm_w'(1);

  // --------------------------------------------------------------------------
  // Synchroniser: idles high so reset looks like a released key
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Debouncer: the synchronised level must disagree with the stable level for
  // CNT_MAX consecutive cycles before it is accepted.
  // --------------------------------------------------------------------------
  logic               r_stable;
  logic [c_deb_w-1:0] r_deb_cnt;
  logic               w_differ;
  logic               w_settle;
  logic               w_press;
  logic               w_release;

  assign w_differ  = (r_sync2 != r_stable);
  assign w_settle  = w_differ && (r_deb_cnt == c_deb_last);
  // Strobes coincide with the edge that updates the stable level
  assign w_press   = w_settle && !r_sync2;
  assign w_release = w_settle &&  r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable  <= 1'b1;
      r_deb_cnt <= c_deb_zero;
    end else if (!w_differ) begin
      r_deb_cnt <= c_deb_zero;
    end else if (w_settle) begin
      r_stable  <= r_sync2;
      r_deb_cnt <= c_deb_zero;
    end else begin
      r_deb_cnt <= r_deb_cnt + c_deb_one;
    end
  end

  assign key_stable = r_stable;

  // --------------------------------------------------------------------------
  // Classifier: the timer is cleared on every state entry; flags are
  // registered one-cycle pulses.
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [c_tm_w-1:0] r_tm;
  logic              r_single;
  logic              r_double;
  logic              r_long;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_tm     <= c_tm_zero;
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_single <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      case (r_state)
        c_st_idle: begin
          r_tm <= c_tm_zero;
          if (w_press) begin
            r_state <= c_st_press1;
          end
        end

        c_st_press1: begin
          // A release on the very cycle the hold qualifies is still a click
          if (w_release) begin
            r_state <= c_st_gap;
            r_tm    <= c_tm_zero;
          end else if (r_tm == c_long_last) begin
            r_long  <= 1'b1;
            r_state <= c_st_lhold;
            r_tm    <= c_tm_zero;
          end else begin
            r_tm <= r_tm + c_tm_one;
          end
        end

        c_st_lhold: begin
          r_tm <= c_tm_zero;
          if (w_release) begin
            r_state <= c_st_idle;
          end
        end

        c_st_gap: begin
          // A second press arriving on the timeout cycle still makes a double
          if (w_press) begin
            r_state <= c_st_press2;
            r_tm    <= c_tm_zero;
          end else if (r_tm == c_gap_last) begin
            r_single <= 1'b1;
            r_state  <= c_st_idle;
            r_tm     <= c_tm_zero;
          end else begin
            r_tm <= r_tm + c_tm_one;
          end
        end

        c_st_press2: begin
          r_tm <= c_tm_zero;
          if (w_release) begin
            r_double <= 1'b1;
            r_state  <= c_st_idle;
          end
        end

        default: begin
          r_state <= c_st_idle;
          r_tm    <= c_tm_zero;
        end
      endcase
    end
  end

  assign single_flag = r_single;
  assign double_flag = r_double;
  assign long_flag   = r_long;

endmodule
`default_nettype wire

// File: rtl/key_event_multi.sv
`default_nettype none
// ============================================================================
// Module      : key_event_multi
// Description : Multi-channel key front end. Each active-low key is
//               synchronised, debounced and classified into single-click,
//               double-click and long-press one-cycle flags. Channels are
//               fully independent.
// Ports       : clk         - system clock (50 MHz)
//               rst         - asynchronous active-high reset
//               key_in      - raw key pins, 0 = pressed
//               key_stable  - debounced levels, 0 = pressed
//               single_flag - per-channel single-click pulse
//               double_flag - per-channel double-click pulse
//               long_flag   - per-channel long-press pulse
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_multi
  import key_event_pkg::*;
#(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned CNT_MAX    = c_cnt_max,
  parameter int unsigned DOUBLE_GAP = c_double_gap,
  parameter int unsigned LONG_PRESS = c_long_press
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_stable,
  output logic [KEY_NUM-1:0] single_flag,
  output logic [KEY_NUM-1:0] double_flag,
  output logic [KEY_NUM-1:0] long_flag
);

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_event_chan #(
      .CNT_MAX    (CNT_MAX),
      .DOUBLE_GAP (DOUBLE_GAP),
      .LONG_PRESS (LONG_PRESS)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in[i]),
      .key_stable  (key_stable[i]),
      .single_flag (single_flag[i]),
      .double_flag (double_flag[i]),
      .long_flag   (long_flag[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_key_event_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_multi
// Description : Self-checking bench for key_event_multi. A timestamp-based
//               reference model predicts every output each cycle; directed
//               steps additionally check flag counts per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_multi;

  localparam int KN = 4;
  localparam int CM = 24;
  localparam int DG = 100;
  localparam int LP = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [KN-1:0] key_in = '1;
  logic [KN-1:0] key_stable;
  logic [KN-1:0] single_flag;
  logic [KN-1:0] double_flag;
  logic [KN-1:0] long_flag;

  key_event_multi #(
    .KEY_NUM    (KN),
    .CNT_MAX    (CM),
    .DOUBLE_GAP (DG),
    .LONG_PRESS (LP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_stable  (key_stable),
    .single_flag (single_flag),
    .double_flag (double_flag),
    .long_flag   (long_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // --------------------------------------------------------------------------
  // Reference model: raw pin -> 2-cycle delay -> accept after CM consecutive
  // disagreeing cycles; clicks classified from press/release timestamps.
  // --------------------------------------------------------------------------
  longint        t;
  logic [KN-1:0] m_s1, m_s, m_stable, m_single, m_double, m_long;
  int            run     [KN];
  bit            active  [KN];
  bit            held    [KN];
  bit            waiting [KN];
  bit            second  [KN];
  bit            longd   [KN];
  longint        t0      [KN];
  longint        trel    [KN];
  bit            mp, mr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t = 0;
      m_s1 = '1; m_s = '1; m_stable = '1;
      m_single = '0; m_double = '0; m_long = '0;
      for (int c = 0; c < KN; c++) begin
        run[c] = 0; active[c] = 0; held[c] = 0; waiting[c] = 0;
        second[c] = 0; longd[c] = 0; t0[c] = 0; trel[c] = 0;
      end
    end else begin
      t = t + 1;
      for (int c = 0; c < KN; c++) begin
        m_single[c] = 1'b0; m_double[c] = 1'b0; m_long[c] = 1'b0;
        mp = 0; mr = 0;
        if (m_s[c] != m_stable[c]) run[c] = run[c] + 1;
        else run[c] = 0;
        if (run[c] == CM) begin
          run[c] = 0;
          m_stable[c] = m_s[c];
          mp = !m_s[c];
          mr = m_s[c];
        end
        m_s[c]  = m_s1[c];
        m_s1[c] = key_in[c];

        if (mp) begin
          if (active[c] && waiting[c]) begin
            waiting[c] = 0; held[c] = 1; second[c] = 1;
          end else if (!active[c]) begin
            active[c] = 1; held[c] = 1; second[c] = 0; longd[c] = 0; t0[c] = t;
          end
        end else if (mr) begin
          if (active[c] && held[c]) begin
            held[c] = 0;
            if (longd[c]) active[c] = 0;
            else if (second[c]) begin m_double[c] = 1'b1; active[c] = 0; end
            else begin waiting[c] = 1; trel[c] = t; end
          end
        end else if (active[c]) begin
          if (held[c] && !second[c] && !longd[c] && (t - t0[c] == LP)) begin
            m_long[c] = 1'b1; longd[c] = 1;
          end else if (waiting[c] && (t - trel[c] == DG)) begin
            m_single[c] = 1'b1; active[c] = 0; waiting[c] = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model, plus observed flag tallies
  // --------------------------------------------------------------------------
  int cnt_s [KN];
  int cnt_d [KN];
  int cnt_l [KN];
  int cnt_low3 = 0;
  int cnt_both = 0;

  initial begin
    for (int c = 0; c < KN; c++) begin cnt_s[c] = 0; cnt_d[c] = 0; cnt_l[c] = 0; end
  end

  always @(negedge clk) begin
    checks++;
    assert (key_stable === m_stable) else begin
      errors++; $error("FAIL key_stable t=%0t observed=%b expected=%b", $time, key_stable, m_stable);
    end
    checks++;
    assert (single_flag === m_single) else begin
      errors++; $error("FAIL single_flag t=%0t observed=%b expected=%b", $time, single_flag, m_single);
    end
    checks++;
    assert (double_flag === m_double) else begin
      errors++; $error("FAIL double_flag t=%0t observed=%b expected=%b", $time, double_flag, m_double);
    end
    checks++;
    assert (long_flag === m_long) else begin
      errors++; $error("FAIL long_flag t=%0t observed=%b expected=%b", $time, long_flag, m_long);
    end
    for (int c = 0; c < KN; c++) begin
      if (single_flag[c] === 1'b1) cnt_s[c] = cnt_s[c] + 1;
      if (double_flag[c] === 1'b1) cnt_d[c] = cnt_d[c] + 1;
      if (long_flag[c]   === 1'b1) cnt_l[c] = cnt_l[c] + 1;
    end
    if (key_stable[3] !== 1'b1) cnt_low3++;
    if (single_flag[0] === 1'b1 && long_flag[2] === 1'b1) cnt_both++;
  end

  // --------------------------------------------------------------------------
  // Directed-step helpers
  // --------------------------------------------------------------------------
  int b_s [KN];
  int b_d [KN];
  int b_l [KN];
  int b_low3, b_both;

  task automatic win_start();
    #1;
    for (int c = 0; c < KN; c++) begin b_s[c] = cnt_s[c]; b_d[c] = cnt_d[c]; b_l[c] = cnt_l[c]; end
    b_low3 = cnt_low3;
    b_both = cnt_both;
  endtask

  function automatic int total_flags();
    int sum = 0;
    for (int c = 0; c < KN; c++)
      sum += (cnt_s[c] - b_s[c]) + (cnt_d[c] - b_d[c]) + (cnt_l[c] - b_l[c]);
    return sum;
  endfunction

  task automatic expect_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_vec(input string tag, input logic [KN-1:0] obs, input logic [KN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic hold(input int ch, input logic v, input int n);
    key_in[ch] = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic bounce(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      key_in[ch] = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  int           rem [KN];
  logic [KN-1:0] all_ones;

  initial begin
    all_ones = '1;
    rst = 1'b1;
    key_in = '1;
    repeat (3) @(negedge clk);
    #1;
    expect_vec("reset_key_stable", key_stable, all_ones);
    expect_vec("reset_single", single_flag, '0);
    expect_vec("reset_double", double_flag, '0);
    expect_vec("reset_long", long_flag, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: bouncy single click on ch0
    win_start();
    bounce(0, 10);
    hold(0, 1'b0, 60);
    bounce(0, 10);
    hold(0, 1'b1, 250);
    win_start_check_single0: begin
      #1;
      expect_int("t1_single0", cnt_s[0] - b_s[0], 1);
      expect_int("t1_total", total_flags(), 1);
    end

    // 2: clean double click on ch1
    win_start();
    hold(1, 1'b0, 50);
    hold(1, 1'b1, 40);
    hold(1, 1'b0, 50);
    hold(1, 1'b1, 250);
    #1;
    expect_int("t2_double1", cnt_d[1] - b_d[1], 1);
    expect_int("t2_single1", cnt_s[1] - b_s[1], 0);
    expect_int("t2_total", total_flags(), 1);

    // 3: long press on ch2
    win_start();
    hold(2, 1'b0, 300);
    hold(2, 1'b1, 250);
    #1;
    expect_int("t3_long2", cnt_l[2] - b_l[2], 1);
    expect_int("t3_total", total_flags(), 1);

    // 4a: second press strobe lands on the gap timeout cycle
    win_start();
    hold(0, 1'b0, 40);
    hold(0, 1'b1, DG);
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 250);
    #1;
    expect_int("t4_edge_double0", cnt_d[0] - b_d[0], 1);
    expect_int("t4_edge_single0", cnt_s[0] - b_s[0], 0);

    // 4b: gap just over the limit gives two singles
    win_start();
    hold(0, 1'b0, 40);
    hold(0, 1'b1, DG + 10);
    hold(0, 1'b0, 40);
    hold(0, 1'b1, 250);
    #1;
    expect_int("t4_late_single0", cnt_s[0] - b_s[0], 2);
    expect_int("t4_late_total", total_flags(), 2);

    // 5a: short glitches on ch3 are ignored
    win_start();
    for (int i = 0; i < 5; i++) begin
      hold(3, 1'b0, CM - 4);
      hold(3, 1'b1, 20);
    end
    repeat (50) @(negedge clk);
    #1;
    expect_int("t5_glitch_low3", cnt_low3 - b_low3, 0);
    expect_int("t5_glitch_total", total_flags(), 0);

    // 5b: single on ch0 and long on ch2 in the same cycle
    win_start();
    key_in[2] = 1'b0;
    repeat (40) @(negedge clk);
    key_in[0] = 1'b0;
    repeat (DG - 40) @(negedge clk);
    key_in[0] = 1'b1;
    repeat (200) @(negedge clk);
    key_in[2] = 1'b1;
    repeat (250) @(negedge clk);
    #1;
    expect_int("t5_same_cycle", cnt_both - b_both, 1);
    expect_int("t5_single0", cnt_s[0] - b_s[0], 1);
    expect_int("t5_long2", cnt_l[2] - b_l[2], 1);

    // 6: reset during PRESS2 of ch1
    hold(1, 1'b0, 40);
    hold(1, 1'b1, 30);
    key_in[1] = 1'b0;
    repeat (CM + 10) @(negedge clk);
    #1;
    expect_int("t6_pressed_before_rst", int'(key_stable[1]), 0);
    #1;
    rst = 1'b1;
    #1;
    expect_vec("t6_async_key_stable", key_stable, all_ones);
    expect_vec("t6_async_single", single_flag, '0);
    expect_vec("t6_async_double", double_flag, '0);
    expect_vec("t6_async_long", long_flag, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    win_start();
    repeat (5) @(negedge clk);
    key_in[1] = 1'b1;
    repeat (300) @(negedge clk);
    #1;
    expect_int("t6_double1", cnt_d[1] - b_d[1], 0);
    expect_int("t6_total", total_flags(), 0);

    // Random phase: independent random hold times on every channel
    for (int c = 0; c < KN; c++) rem[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < KN; c++) begin
        if (rem[c] == 0) begin
          key_in[c] = 1'($urandom_range(0, 1));
          rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30))
                                               : int'($urandom_range(20, 260));
        end
        rem[c]--;
      end
      @(negedge clk);
    end
    key_in = '1;
    repeat (400) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
